// File: rtl/demm_stream_pkg.sv
// rtl/demm_stream_pkg.sv - shared types and helpers for the DEMM stream blocks
package demm_stream_pkg;

    typedef enum logic {FILL, ISSUE} scatter_state_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_stream_scatter_if.sv
// rtl/fp_stream_scatter_if.sv - single-lane valid/ready stream with master/slave views
interface fp_stream_scatter_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/fp_stream_scatter.sv
// rtl/fp_stream_scatter.sv - serial fp16 stream to DATA_SIZE parallel lanes
// Optional tlast zero-padding of short vectors under SCATTER_TLAST_PAD_EN.
module fp_stream_scatter
    import demm_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_SIZE  = 16
) (
    input  logic                clk,
    input  logic                rst,
    fp_stream_scatter_if.slave  din_s,
    input  logic                din_tlast,
    fp_stream_scatter_if.master dout_s [DATA_SIZE],
    output logic                busy
);

    localparam int IW = idx_w(DATA_SIZE);
    localparam logic [IW-1:0] LAST = IW'(DATA_SIZE - 1);

    scatter_state_t        state;
    logic [IW-1:0]         idx;
    logic [DATA_SIZE-1:0]  pending;
    logic [DATA_SIZE-1:0]  accepted;
    logic [DATA_WIDTH-1:0] vec_buf [DATA_SIZE];
    logic                  rdy;
    logic                  pad_end;

`ifdef SCATTER_TLAST_PAD_EN
    assign pad_end = din_tlast && (idx != LAST);
`else
    logic unused_tlast;
    assign unused_tlast = din_tlast;
    assign pad_end      = 1'b0;
`endif

    assign din_s.tready = rdy;
    assign busy         = (state == ISSUE);

    for (genvar i = 0; i < DATA_SIZE; i++) begin : g_lane
        assign dout_s[i].tvalid = pending[i];
        assign dout_s[i].tdata  = vec_buf[i];
        assign accepted[i]      = pending[i] & dout_s[i].tready;
    end

    // rdy tracks the next state so input and output phases never overlap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            idx     <= '0;
            pending <= '0;
            rdy     <= 1'b0;
            for (int j = 0; j < DATA_SIZE; j++) vec_buf[j] <= '0;
        end else begin
            case (state)
                FILL: begin
                    rdy <= 1'b1;
                    if (din_s.tvalid && rdy) begin
                        vec_buf[idx] <= din_s.tdata;
`ifdef SCATTER_TLAST_PAD_EN
                        if (pad_end) begin
                            for (int j = 0; j < DATA_SIZE; j++)
                                if (j > int'(idx)) vec_buf[j] <= DATA_WIDTH'(FP16_ZERO);
                        end
`endif
                        if (idx == LAST || pad_end) begin
                            idx     <= '0;
                            pending <= '1;
                            state   <= ISSUE;
                            rdy     <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    pending <= pending & ~accepted;
                    rdy     <= 1'b0;
                    if ((pending & ~accepted) == '0) begin
                        state <= FILL;
                        rdy   <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_stream_scatter.sv
// tb/tb_fp_stream_scatter.sv - directed bench for fp_stream_scatter (16 x fp16)
module tb_fp_stream_scatter;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_tvalid = 1'b0;
    logic [15:0] din_tdata = '0;
    logic        din_tlast = 1'b0;
    logic        din_tready;
    logic [N-1:0] lane_rdy = '1;
    logic [N-1:0] lane_valid;
    logic [15:0] lane_data [N];
    logic        busy;

    int checks = 0;
    int failures = 0;
    int vec_done = 0;
    int hs_cnt [N] = '{default: 0};

    always #5 clk = ~clk;

    fp_stream_scatter_if #(.DATA_WIDTH(16)) din ();
    fp_stream_scatter_if #(.DATA_WIDTH(16)) lanes [N] ();

    assign din.tvalid = din_tvalid;
    assign din.tdata  = din_tdata;
    assign din_tready = din.tready;

    for (genvar g = 0; g < N; g++) begin : g_l
        assign lanes[g].tready = lane_rdy[g];
        assign lane_valid[g]   = lanes[g].tvalid;
        assign lane_data[g]    = lanes[g].tdata;
    end

    fp_stream_scatter #(.DATA_WIDTH(16), .DATA_SIZE(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .din_s     (din),
        .din_tlast (din_tlast),
        .dout_s    (lanes),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (!rst)
            for (int i = 0; i < N; i++)
                if (lane_valid[i] && lane_rdy[i]) hs_cnt[i] <= hs_cnt[i] + 1;
    end

    typedef struct {
        logic [15:0] start;
        logic [15:0] step;
        int          stall_lane;
        int          stall_cycles;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l);
        int n = 0;
        din_tvalid = 1'b1;
        din_tdata  = d;
        din_tlast  = l;
        while (!din_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("beat_timeout", 32'd1, 32'd0);
        @(negedge clk);
        din_tvalid = 1'b0;
        din_tlast  = 1'b0;
    endtask

    task automatic feed(input logic [15:0] start, input logic [15:0] step, input int cnt);
        for (int i = 0; i < cnt; i++) send_beat(16'(start + step * 16'(i)), 1'b0);
    endtask

    task automatic check_lanes(input string tag, input logic [15:0] start, input logic [15:0] step);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_lane%0d", tag, i), {16'h0, lane_data[i]},
                  {16'h0, 16'(start + step * 16'(i))});
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_valid"}, {16'h0, lane_valid}, 32'h0);
        check({tag, "_tready"}, {31'h0, din_tready}, 32'h1);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        tbl[0] = '{16'h3C00, 16'h3C00, 0, 0};
        tbl[1] = '{16'h0001, 16'h0001, 3, 10};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 15, 3};
        tbl[3] = '{16'hAAAA, 16'h0111, 0, 1};

        // reset held for 5 cycles
        repeat (5) begin
            @(negedge clk);
            check("rst_valid", {16'h0, lane_valid}, 32'h0);
            check("rst_tready", {31'h0, din_tready}, 32'h0);
            check("rst_busy", {31'h0, busy}, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tready", {31'h0, din_tready}, 32'h1);

        for (int r = 0; r < 4; r++) begin
            logic [N-1:0] smask;
            smask    = (tbl[r].stall_cycles > 0) ? N'(1 << tbl[r].stall_lane) : '0;
            lane_rdy = ~smask;
            feed(tbl[r].start, tbl[r].step, N);
            check($sformatf("v%0d_allvalid", r), {16'h0, lane_valid}, 32'h0000FFFF);
            check($sformatf("v%0d_busy", r), {31'h0, busy}, 32'h1);
            check($sformatf("v%0d_tready_lo", r), {31'h0, din_tready}, 32'h0);
            check_lanes($sformatf("v%0d", r), tbl[r].start, tbl[r].step);
            if (tbl[r].stall_cycles > 0) begin
                for (int k = 0; k < tbl[r].stall_cycles; k++) begin
                    @(negedge clk);
                    check($sformatf("v%0d_stall_valid", r), {16'h0, lane_valid}, {16'h0, smask});
                    check($sformatf("v%0d_stall_tready", r), {31'h0, din_tready}, 32'h0);
                    check($sformatf("v%0d_stall_data", r), {16'h0, lane_data[tbl[r].stall_lane]},
                          {16'h0, 16'(tbl[r].start + tbl[r].step * 16'(tbl[r].stall_lane))});
                end
                lane_rdy = '1;
            end
            @(negedge clk);
            check_drained($sformatf("v%0d_drain", r));
            vec_done++;
        end

        // lanes 0 and 15 finish in the same cycle
        lane_rdy = 16'h7FFE;
        feed(16'h5000, 16'h0010, N);
        @(negedge clk);
        check("sim_two_left", {16'h0, lane_valid}, 32'h00008001);
        lane_rdy = '1;
        @(negedge clk);
        check_drained("sim_drain");
        @(negedge clk);
        check_drained("sim_idle");
        vec_done++;

`ifdef SCATTER_TLAST_PAD_EN
        send_beat(16'h3C00, 1'b0);
        send_beat(16'h4000, 1'b0);
        send_beat(16'h4200, 1'b0);
        send_beat(16'h4400, 1'b0);
        send_beat(16'h4500, 1'b1);
        check("pad_valid", {16'h0, lane_valid}, 32'h0000FFFF);
        check("pad_l0", {16'h0, lane_data[0]}, 32'h3C00);
        check("pad_l4", {16'h0, lane_data[4]}, 32'h4500);
        for (int i = 5; i < N; i++)
            check($sformatf("pad_zero%0d", i), {16'h0, lane_data[i]}, 32'h0);
        @(negedge clk);
        check_drained("pad_drain");
        vec_done++;
`else
        send_beat(16'h3C00, 1'b0);
        send_beat(16'h4000, 1'b0);
        send_beat(16'h4200, 1'b0);
        send_beat(16'h4400, 1'b0);
        send_beat(16'h4500, 1'b1);
        check_drained("tlast_ignored");
        feed(16'h0100, 16'h0001, 11);
        check("nopad_valid", {16'h0, lane_valid}, 32'h0000FFFF);
        check("nopad_l4", {16'h0, lane_data[4]}, 32'h4500);
        check("nopad_l5", {16'h0, lane_data[5]}, 32'h0100);
        check("nopad_l15", {16'h0, lane_data[15]}, 32'h010A);
        @(negedge clk);
        check_drained("nopad_drain");
        vec_done++;
`endif

        // reset in the middle of a vector
        feed(16'h7700, 16'h0001, 7);
        rst = 1'b1;
        #1;
        check("midrst_tready", {31'h0, din_tready}, 32'h0);
        check("midrst_valid", {16'h0, lane_valid}, 32'h0);
        @(negedge clk);
        check("midrst_buf_l0", {16'h0, lane_data[0]}, 32'h0);
        check("midrst_buf_l6", {16'h0, lane_data[6]}, 32'h0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_drained("after_midrst");
        end
        feed(16'h1000, 16'h0001, N);
        check("fresh_valid", {16'h0, lane_valid}, 32'h0000FFFF);
        check_lanes("fresh", 16'h1000, 16'h0001);
        @(negedge clk);
        check_drained("fresh_drain");
        vec_done++;

        @(negedge clk);
        for (int i = 0; i < N; i++)
            check($sformatf("hs_cnt%0d", i), 32'(hs_cnt[i]), 32'(vec_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
